lfsr_delay_gen: RTL and testbench

Parametrised Fibonacci LFSR with a built-in random-delay timer. It generates a pseudo-random bit and word stream, supports runtime seeding, and guards against lock-up. On request it waits a random number of ticks, then emits a one-cycle done pulse. Used by game control for randomised start/round delays; tick comes from the system prescaler.

---
 rtl/lfsr_delay_gen.sv | 103 ++++++++++
 tb/tb_lfsr_delay_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_delay_gen.sv
// Fibonacci LFSR random source with a random-length tick timer; outputs are registered, one-cycle done pulse.
// start is only honoured while idle; requests arriving while busy or done are dropped.
module lfsr_delay_gen #(
  parameter int               WIDTH      = 10,
  parameter logic [WIDTH-1:0] TAPS       = 10'b0000001001,
  parameter logic [WIDTH-1:0] SEED       = 1,
  parameter int               DELAY_BITS = 8,
  parameter int               MIN_DELAY  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             start,
  input  logic             cancel,
  input  logic             tick,
  output logic             rand_bit,
  output logic [WIDTH-1:0] rand_word,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(MIN_DELAY + 2**DELAY_BITS);
  // The all-zero state would lock the register, so it is never loaded.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    load_val;
  logic             fb;

  always_comb begin
    fb       = ^(lfsr_q & TAPS);
    load_val = CW'(MIN_DELAY) + CW'(lfsr_q[DELAY_BITS-1:0]);

    lfsr_d = lfsr_q;
    if (seed_load) begin
      lfsr_d = (seed_in == '0) ? WIDTH'(1) : seed_in;
    end else if (en) begin
      lfsr_d = {fb, lfsr_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = load_val;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A zero count only occurs with no fixed offset and expires without a tick.
        if (cancel) begin
          count_d = '0;
          state_d = IDLE;
        end else if (count_q == '0) begin
          state_d = DONE;
        end else if (tick) begin
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= SEED_EFF;
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign rand_bit  = lfsr_q[0];
  assign rand_word = lfsr_q;
  assign busy      = (state_q == WAIT);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_lfsr_delay_gen.sv
// Scoreboard bench for lfsr_delay_gen: default instance plus a MIN_DELAY=0 instance.
module tb_lfsr_delay_gen;

  localparam int W = 10;
  localparam int unsigned TAPS_M = 32'h009;

  typedef struct packed {
    logic         rst;
    logic         en;
    logic         seed_load;
    logic [W-1:0] seed_in;
    logic         start;
    logic         cancel;
    logic         tick;
  } in_t;

  // phase: 0 = idle, 1 = timing, 2 = done pulse
  typedef struct {
    int unsigned lfsr;
    int          phase;
    int          remaining;
  } mdl_t;

  typedef struct packed {
    logic [12:0] o1;
    logic [12:0] o2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t a, b;
  logic         rb1, busy1, done1, rb2, busy2, done2;
  logic [W-1:0] rw1, rw2;

  lfsr_delay_gen u_dut (
    .clk(clk), .rst(a.rst), .en(a.en), .seed_load(a.seed_load), .seed_in(a.seed_in),
    .start(a.start), .cancel(a.cancel), .tick(a.tick),
    .rand_bit(rb1), .rand_word(rw1), .busy(busy1), .done(done1)
  );

  lfsr_delay_gen #(.WIDTH(10), .TAPS(10'b0000001001), .SEED(10'd1), .DELAY_BITS(8), .MIN_DELAY(0)) u_dut0 (
    .clk(clk), .rst(b.rst), .en(b.en), .seed_load(b.seed_load), .seed_in(b.seed_in),
    .start(b.start), .cancel(b.cancel), .tick(b.tick),
    .rand_bit(rb2), .rand_word(rw2), .busy(busy2), .done(done2)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  mdl_t m1, m2;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic int unsigned lfsr_next(input int unsigned s);
    int unsigned fb;
    fb = $countones(s & TAPS_M) % 2;
    return (s >> 1) | (fb << (W - 1));
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input in_t i, input int min_d);
    mdl_t n;
    n = m;
    if (i.rst) begin
      n.lfsr = 1; n.phase = 0; n.remaining = 0;
      return n;
    end
    case (m.phase)
      0: if (i.start) begin
        n.remaining = min_d + int'(m.lfsr % 256);
        n.phase = 1;
      end
      1: begin
        if (i.cancel) n.phase = 0;
        else if (m.remaining == 0) n.phase = 2;
        else if (i.tick) begin
          n.remaining = m.remaining - 1;
          if (n.remaining == 0) n.phase = 2;
        end
      end
      default: n.phase = 0;
    endcase
    if (i.seed_load) n.lfsr = (i.seed_in == '0) ? 1 : int'(i.seed_in);
    else if (i.en) n.lfsr = lfsr_next(m.lfsr);
    return n;
  endfunction

  function automatic logic [12:0] outs(input mdl_t m);
    logic [W-1:0] w;
    w = W'(m.lfsr);
    return {w[0], (m.phase == 1), (m.phase == 2), w};
  endfunction

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    exp_t e;
    m1 = mstep(m1, a, 16);
    m2 = mstep(m2, b, 0);
    e.o1 = outs(m1);
    e.o2 = outs(m2);
    q.push_back(e);
    @(negedge clk);
    a.rst = 0; a.seed_load = 0; a.start = 0; a.cancel = 0;
    b.rst = 0; b.seed_load = 0; b.start = 0; b.cancel = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_dut", 32'({rb1, busy1, done1, rw1}), 32'(e.o1));
        check("sb_dut_min0", 32'({rb2, busy2, done2, rw2}), 32'(e.o2));
      end
    end
  end

  initial begin : driver
    int first_ret;
    int ticks;
    bit got_done;
    m1 = '{lfsr: 1, phase: 0, remaining: 0};
    m2 = '{lfsr: 1, phase: 0, remaining: 0};
    a = '0; b = '0;
    a.rst = 1; b.rst = 1;
    @(negedge clk);
    step();
    check("reset_word", 32'(rw1), 32'h001);
    check("reset_busy", 32'(busy1), 0);
    check("reset_done", 32'(done1), 0);

    // full LFSR cycle
    a.en = 1;
    step();
    check("first_step", 32'(rw1), 32'h200);
    first_ret = 0;
    for (int k = 2; k <= 1023; k++) begin
      step();
      if (rw1 == 10'h001 && first_ret == 0) first_ret = k;
    end
    check("period", 32'(first_ret), 1023);

    // seeding
    a.en = 0; a.seed_load = 1; a.seed_in = '0;
    step();
    check("seed_zero", 32'(rw1), 32'h001);
    a.en = 1; a.seed_load = 1; a.seed_in = 10'h155;
    step();
    check("seed_wins", 32'(rw1), 32'h155);
    a.en = 0; a.seed_load = 1; a.seed_in = 10'h001;
    step();

    // continuous tick: done at T+18
    a.tick = 1; a.start = 1;
    step();
    check("t3_busy_start", 32'(busy1), 1);
    for (int k = 1; k <= 17; k++) begin
      step();
      check("t3_done", 32'(done1), 32'(k == 17));
      check("t3_busy", 32'(busy1), 32'(k < 17));
    end
    step();
    check("t3_done_pulse_end", 32'(done1), 0);

    // sparse ticks with ignored starts
    a.tick = 0; a.start = 1;
    step();
    ticks = 0; got_done = 0;
    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      a.tick = (cyc % 4 == 3);
      a.start = (cyc % 5 == 2);
      if (a.tick) ticks++;
      step();
      if (done1) got_done = 1;
    end
    check("t4_done_seen", 32'(got_done), 1);
    check("t4_tick_count", 32'(ticks), 17);
    a.tick = 0; a.start = 0;
    step();

    // cancel together with tick
    a.start = 1;
    step();
    a.tick = 1;
    repeat (3) step();
    a.cancel = 1;
    step();
    check("t5_cancel_busy", 32'(busy1), 0);
    check("t5_cancel_done", 32'(done1), 0);
    a.tick = 0; a.start = 1;
    step();
    check("t5_restart_busy", 32'(busy1), 1);
    a.cancel = 1;
    step();

    // reset mid-delay
    a.start = 1; a.tick = 1;
    step();
    repeat (5) step();
    a.rst = 1;
    step();
    check("t6_rst_busy", 32'(busy1), 0);
    check("t6_rst_done", 32'(done1), 0);
    check("t6_rst_word", 32'(rw1), 32'h001);
    a.tick = 0;

    // zero-length delay
    b.seed_load = 1; b.seed_in = 10'h100;
    step();
    b.start = 1;
    step();
    check("t6b_busy", 32'(busy2), 1);
    check("t6b_no_done_yet", 32'(done2), 0);
    step();
    check("t6b_done", 32'(done2), 1);
    step();
    check("t6b_done_end", 32'(done2), 0);

    // randomized traffic on both instances
    for (int n = 0; n < 6000; n++) begin
      a.rst = ($urandom_range(0, 299) == 0);
      a.en = 1'($urandom_range(0, 1));
      a.seed_load = ($urandom_range(0, 49) == 0);
      a.seed_in = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      a.start = ($urandom_range(0, 7) == 0);
      a.cancel = ($urandom_range(0, 299) == 0);
      a.tick = 1'($urandom_range(0, 1));
      b.rst = ($urandom_range(0, 299) == 0);
      b.en = 1'($urandom_range(0, 1));
      b.seed_load = ($urandom_range(0, 19) == 0);
      b.seed_in = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 3) << 8) : W'($urandom);
      b.start = ($urandom_range(0, 7) == 0);
      b.cancel = ($urandom_range(0, 299) == 0);
      b.tick = ($urandom_range(0, 3) == 0);
      step();
    end

    a = '0; b = '0;
    step();
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
